// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- serial transmitter end of the UART controller.
//
// Takes a byte written by io_ctl into a single-entry holding register and
// shifts it out on tx, LSB first, one bit per baud tick. Because the holding
// register is separate from the shift register, a byte written during a frame
// is started directly after the current frame's last stop bit, with no idle
// gap on the line.
//
// Frame on tx: start(0), DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits (1). Every bit lasts exactly one tick period.
//
// Parameters
//   DATA_BITS  data bits per frame (5..8)
//   PARITY     0 = none, 1 = even, 2 = odd
//   STOP_BITS  stop bits per frame (1 or 2)
//
// Ports
//   clk      system clock, all logic on the rising edge
//   rst      synchronous reset, active-high
//   bclk     baud clock level from baud_gen (already clk-synchronous)
//   din      byte to transmit
//   wr       write strobe, accepted when wr & tx_rdy on a clk edge
//   tx       serial line, idle high
//   tx_rdy   holding register empty, a byte can be accepted
//   tx_done  one-clk pulse at the end of the last stop bit of each frame
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bclk,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 wr,
  output logic                 tx,
  output logic                 tx_rdy,
  output logic                 tx_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q,     state_d;
  logic                 bclk_q,      bclk_d;
  logic [DATA_BITS-1:0] hold_q,      hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] shreg_q,     shreg_d;
  logic                 par_q,       par_d;
  logic [3:0]           bit_cnt_q,   bit_cnt_d;
  logic                 stop_cnt_q,  stop_cnt_d;
  logic                 tx_q,        tx_d;
  logic                 tx_done_q,   tx_done_d;

  logic tick;
  logic wr_acc;
  logic load_go;

  // One tick per bclk rising edge, however long bclk stays high.
  assign tick   = bclk & ~bclk_q;
  // Write and load are mutually exclusive: a load needs hold_full_q=1,
  // an accepted write needs hold_full_q=0.
  assign wr_acc = wr & ~hold_full_q;

  always_comb begin
    state_d     = state_q;
    bclk_d      = bclk;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    par_d       = par_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    tx_d        = tx_q;
    tx_done_d   = 1'b0;
    load_go     = 1'b0;

    if (wr_acc) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (hold_full_q) load_go = 1'b1;
          else             tx_d    = 1'b1;
        end

        // Start bit has run its period; put data bit 0 on the line.
        S_START: begin
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end

        // Bit 0 went out leaving START, so DATA_BITS-1 more shifts here;
        // the tick after the last data bit opens parity or stop.
        S_DATA: begin
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            stop_cnt_d = 1'b0;
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end

        S_PARITY: begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end

        // tx is already high; each tick ends one stop bit.
        S_STOP: begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            tx_done_d = 1'b1;
            if (hold_full_q) begin
              load_go = 1'b1;
            end else begin
              tx_d    = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            stop_cnt_d = 1'b1;
          end
        end

        default: begin
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end

    // Move the held byte into the shifter and drive the start bit. Parity
    // is fixed here from the full byte so shifting does not disturb it.
    if (load_go) begin
      shreg_d     = hold_q;
      par_d       = (^hold_q) ^ (PARITY == 2);
      hold_full_d = 1'b0;
      tx_d        = 1'b0;
      state_d     = S_START;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bclk_q      <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      tx_q        <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bclk_q      <= bclk_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      par_q       <= par_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      tx_q        <= tx_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_rdy  = ~hold_full_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: an 8N1 instance, an even-parity 1-stop
// instance and an odd-parity 2-stop instance share all inputs.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic       bclk;
  logic [7:0] din;
  logic       wr;
  logic       tx,   tx_rdy,   tx_done;
  logic       tx_e, tx_rdy_e, tx_done_e;
  logic       tx_o, tx_rdy_o, tx_done_o;

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .bclk(bclk), .din(din), .wr(wr),
    .tx(tx), .tx_rdy(tx_rdy), .tx_done(tx_done)
  );

  uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_e (
    .clk(clk), .rst(rst), .bclk(bclk), .din(din), .wr(wr),
    .tx(tx_e), .tx_rdy(tx_rdy_e), .tx_done(tx_done_e)
  );

  uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_o (
    .clk(clk), .rst(rst), .bclk(bclk), .din(din), .wr(wr),
    .tx(tx_o), .tx_rdy(tx_rdy_o), .tx_done(tx_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bclk pulse; returns at the falling clk edge after the tick edge.
  task automatic tick();
    @(negedge clk) bclk = 1'b1;
    @(negedge clk) bclk = 1'b0;
  endtask

  task automatic write(input logic [7:0] d);
    @(negedge clk) begin din = d; wr = 1'b1; end
    @(negedge clk) wr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) begin rst = 1'b1; wr = 1'b0; bclk = 1'b0; end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // n ticks on the 8N1 instance; seq[i]/done[i] are tx/tx_done after tick i.
  task automatic run_main(input string tag, input logic [31:0] seq,
                          input logic [31:0] done, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s tx[%0d]", tag, i), {31'd0, tx}, {31'd0, seq[i]});
      chk($sformatf("%s done[%0d]", tag, i), {31'd0, tx_done}, {31'd0, done[i]});
    end
  endtask

  initial begin
    rst = 1'b1; bclk = 1'b0; din = 8'h00; wr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state and idle line
    chk("rst tx",      {31'd0, tx},      32'd1);
    chk("rst tx_rdy",  {31'd0, tx_rdy},  32'd1);
    chk("rst tx_done", {31'd0, tx_done}, 32'd0);
    run_main("idle", 32'hFFFFF, 32'h0, 20);
    chk("idle tx_rdy", {31'd0, tx_rdy}, 32'd1);

    // 8N1 0x55
    write(8'h55);
    chk("55 rdy after wr", {31'd0, tx_rdy}, 32'd0);
    tick();
    chk("55 start", {31'd0, tx}, 32'd0);
    chk("55 rdy after load", {31'd0, tx_rdy}, 32'd1);
    run_main("55", 32'h355, 32'h200, 10);
    @(negedge clk);
    chk("55 done one clk", {31'd0, tx_done}, 32'd0);

    // back-to-back A5 then 3C; write while full is dropped
    write(8'hA5);
    tick();
    chk("A5 start", {31'd0, tx}, 32'd0);
    write(8'h3C);
    write(8'hFF);
    chk("full rdy", {31'd0, tx_rdy}, 32'd0);
    run_main("A5", 32'h1A5, 32'h200, 10);
    chk("3C rdy after load", {31'd0, tx_rdy}, 32'd1);
    run_main("3C", 32'h73C, 32'h200, 11);

    // parity and two stop bits, byte 0x07
    do_reset();
    write(8'h07);
    chk("par rdy e", {31'd0, tx_rdy_e}, 32'd0);
    chk("par rdy o", {31'd0, tx_rdy_o}, 32'd0);
    for (int i = 0; i < 13; i++) begin
      logic [31:0] se, de, so, d_o;
      se = 32'h1E0E; de = 32'h0800; so = 32'h1C0E; d_o = 32'h1000;
      tick();
      chk($sformatf("even tx[%0d]", i),   {31'd0, tx_e},      {31'd0, se[i]});
      chk($sformatf("even done[%0d]", i), {31'd0, tx_done_e}, {31'd0, de[i]});
      chk($sformatf("odd tx[%0d]", i),    {31'd0, tx_o},      {31'd0, so[i]});
      chk($sformatf("odd done[%0d]", i),  {31'd0, tx_done_o}, {31'd0, d_o[i]});
    end

    // reset in the middle of the data bits of 0x00
    do_reset();
    write(8'h00);
    tick();
    tick();
    tick();
    chk("abort pre tx", {31'd0, tx}, 32'd0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    chk("abort tx",      {31'd0, tx},      32'd1);
    chk("abort tx_rdy",  {31'd0, tx_rdy},  32'd1);
    chk("abort tx_done", {31'd0, tx_done}, 32'd0);
    rst = 1'b0;
    run_main("abort idle", 32'hFFF, 32'h0, 12);

    // bclk stuck high: a single advance; write while full keeps held byte
    write(8'h0F);
    @(negedge clk) bclk = 1'b1;
    @(negedge clk);
    chk("hold start", {31'd0, tx}, 32'd0);
    write(8'hAA);
    write(8'h55);
    chk("hold rdy", {31'd0, tx_rdy}, 32'd0);
    repeat (45) @(negedge clk);
    chk("hold tx", {31'd0, tx}, 32'd0);
    bclk = 1'b0;
    @(negedge clk);
    run_main("hold", 32'hEA90F, 32'h80200, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
